// File: rtl/fas_pkg.sv
// fas_pkg: shared definitions for the FAS FFT arithmetic blocks.
//   - FAS_MODE_DIF / FAS_MODE_DIT butterfly mode encodings
//   - default word width / fraction bits
//   - fas_acc_t: wide signed scratch type for exact intermediate maths
//   - fas_round_shift: round-half-up arithmetic right shift
//   - fas_sat / fas_sat_ovf: clamp to a signed w-bit range and detect the clamp
package fas_pkg;

  localparam logic FAS_MODE_DIF = 1'b0;
  localparam logic FAS_MODE_DIT = 1'b1;

  localparam int FAS_DW_DEF   = 32;
  localparam int FAS_FRAC_DEF = 16;

  // Wide enough for a full (DW+1)xDW complex product sum at DW up to 62,
  // so helpers never lose bits before the final clamp.
  localparam int FAS_ACC_W = 128;
  typedef logic signed [FAS_ACC_W-1:0] fas_acc_t;

  // Add half an LSB of the result, then shift: round-half-up. sh >= 1.
  function automatic fas_acc_t fas_round_shift(input fas_acc_t v, input int sh);
    fas_acc_t half;
    half = fas_acc_t'(1) <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic fas_acc_t fas_sat_max(input int w);
    return (fas_acc_t'(1) <<< (w - 1)) - fas_acc_t'(1);
  endfunction

  function automatic logic fas_sat_ovf(input fas_acc_t v, input int w);
    fas_acc_t mx;
    mx = fas_sat_max(w);
    return (v > mx) || (v < -mx - fas_acc_t'(1));
  endfunction

  function automatic fas_acc_t fas_sat(input fas_acc_t v, input int w);
    fas_acc_t mx;
    mx = fas_sat_max(w);
    if (v > mx)                      return mx;
    else if (v < -mx - fas_acc_t'(1)) return -mx - fas_acc_t'(1);
    else                             return v;
  endfunction

endpackage

// File: rtl/fas_cmul.sv
// fas_cmul: registered complex multiplier p = a * b with rounded output.
//   a (AW bits signed, re/im) times b (BW bits signed, FRAC fraction bits).
//   Real = ar*br - ai*bi, imag = ar*bi + ai*br, summed exactly, then
//   round-half-up shifted right by FRAC. Output width PW keeps every
//   significant bit of the rounded result.
// Ports: clk, rst (sync, active-high), en (hold when 0),
//        a_re/a_im, b_re/b_im in; p_re/p_im registered out.
module fas_cmul
  import fas_pkg::*;
#(
  parameter  int AW   = 33,
  parameter  int BW   = 32,
  parameter  int FRAC = 16,
  localparam int PW   = AW + BW + 1 - FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [AW-1:0] a_re,
  input  logic signed [AW-1:0] a_im,
  input  logic signed [BW-1:0] b_re,
  input  logic signed [BW-1:0] b_im,
  output logic signed [PW-1:0] p_re,
  output logic signed [PW-1:0] p_im
);

  localparam int MW = AW + BW;

  logic signed [MW-1:0] rr, ii, ri, ir;
  fas_acc_t             re_full, im_full;
  logic signed [PW-1:0] p_re_d, p_im_d, p_re_q, p_im_q;

  always_comb begin
    rr      = MW'(a_re) * MW'(b_re);
    ii      = MW'(a_im) * MW'(b_im);
    ri      = MW'(a_re) * MW'(b_im);
    ir      = MW'(a_im) * MW'(b_re);
    re_full = fas_acc_t'(rr) - fas_acc_t'(ii);
    im_full = fas_acc_t'(ri) + fas_acc_t'(ir);
    p_re_d  = en ? PW'(fas_round_shift(re_full, FRAC)) : p_re_q;
    p_im_d  = en ? PW'(fas_round_shift(im_full, FRAC)) : p_im_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_re_q <= '0;
      p_im_q <= '0;
    end else begin
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end

  assign p_re = p_re_q;
  assign p_im = p_im_q;

endmodule

// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: 3-stage pipelined radix-2 complex butterfly, DIF or DIT
// selected per sample.
//   DIF: a = x + y,   b = (x - y) * w
//   DIT: a = x + y*w, b = x - y*w
//   Optional /2 scaling (round-half-up), saturation to DW bits, sticky ovf.
// Ports: clk, rst (sync, active-high), en (freezes whole pipe when 0),
//        in_valid, mode (0 DIF / 1 DIT), scale, x/y/w re+im in;
//        out_valid, a/b re+im out; ovf sticky flag, clr_ovf clears it.
module fft_bfly_pipe
  import fas_pkg::*;
#(
  parameter int DW   = FAS_DW_DEF,
  parameter int FRAC = FAS_FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic                 scale,
  input  logic signed [DW-1:0] x_re,
  input  logic signed [DW-1:0] x_im,
  input  logic signed [DW-1:0] y_re,
  input  logic signed [DW-1:0] y_im,
  input  logic signed [DW-1:0] w_re,
  input  logic signed [DW-1:0] w_im,
  output logic                 out_valid,
  output logic signed [DW-1:0] a_re,
  output logic signed [DW-1:0] a_im,
  output logic signed [DW-1:0] b_re,
  output logic signed [DW-1:0] b_im,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  localparam int SW = DW + 1;            // exact sum/difference width
  localparam int PW = SW + DW + 1 - FRAC; // rounded product width

  // Valid runs through all three stages; mode/scale are only consumed up to
  // the output stage's combinational logic, so two stages suffice for them.
  logic [2:0] vld_pipe_d, vld_pipe_q;
  logic [1:0] mode_pipe_d, mode_pipe_q, scale_pipe_d, scale_pipe_q;

  // S1: p0 is a (DIF) or x (DIT); p1 is the multiplier operand x-y or y.
  logic signed [SW-1:0] s1_p0_re_d, s1_p0_im_d, s1_p0_re_q, s1_p0_im_q;
  logic signed [SW-1:0] s1_p1_re_d, s1_p1_im_d, s1_p1_re_q, s1_p1_im_q;
  logic signed [DW-1:0] s1_w_re_d, s1_w_im_d, s1_w_re_q, s1_w_im_q;

  // S2: p0 carried alongside the registered product.
  logic signed [SW-1:0] s2_p0_re_d, s2_p0_im_d, s2_p0_re_q, s2_p0_im_q;
  logic signed [PW-1:0] s2_pr_re, s2_pr_im;

  // S3 outputs.
  logic signed [DW-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
  logic signed [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic                 ovf_d, ovf_q;

  fas_acc_t ra_re, ra_im, rb_re, rb_im;
  logic     sat_any;

  always_comb begin
    vld_pipe_d   = en ? {vld_pipe_q[1:0], in_valid} : vld_pipe_q;
    mode_pipe_d  = en ? {mode_pipe_q[0], mode}      : mode_pipe_q;
    scale_pipe_d = en ? {scale_pipe_q[0], scale}    : scale_pipe_q;

    // S1
    s1_p0_re_d = s1_p0_re_q;
    s1_p0_im_d = s1_p0_im_q;
    s1_p1_re_d = s1_p1_re_q;
    s1_p1_im_d = s1_p1_im_q;
    s1_w_re_d  = s1_w_re_q;
    s1_w_im_d  = s1_w_im_q;
    if (en) begin
      s1_w_re_d = w_re;
      s1_w_im_d = w_im;
      if (mode == FAS_MODE_DIT) begin
        s1_p0_re_d = SW'(x_re);
        s1_p0_im_d = SW'(x_im);
        s1_p1_re_d = SW'(y_re);
        s1_p1_im_d = SW'(y_im);
      end else begin
        s1_p0_re_d = SW'(x_re) + SW'(y_re);
        s1_p0_im_d = SW'(x_im) + SW'(y_im);
        s1_p1_re_d = SW'(x_re) - SW'(y_re);
        s1_p1_im_d = SW'(x_im) - SW'(y_im);
      end
    end

    // S2 carry (product is registered inside fas_cmul)
    s2_p0_re_d = en ? s1_p0_re_q : s2_p0_re_q;
    s2_p0_im_d = en ? s1_p0_im_q : s2_p0_im_q;

    // S3: final add/sub, scale, saturate
    if (mode_pipe_q[1] == FAS_MODE_DIT) begin
      ra_re = fas_acc_t'(s2_p0_re_q) + fas_acc_t'(s2_pr_re);
      ra_im = fas_acc_t'(s2_p0_im_q) + fas_acc_t'(s2_pr_im);
      rb_re = fas_acc_t'(s2_p0_re_q) - fas_acc_t'(s2_pr_re);
      rb_im = fas_acc_t'(s2_p0_im_q) - fas_acc_t'(s2_pr_im);
    end else begin
      ra_re = fas_acc_t'(s2_p0_re_q);
      ra_im = fas_acc_t'(s2_p0_im_q);
      rb_re = fas_acc_t'(s2_pr_re);
      rb_im = fas_acc_t'(s2_pr_im);
    end
    if (scale_pipe_q[1]) begin
      ra_re = fas_round_shift(ra_re, 1);
      ra_im = fas_round_shift(ra_im, 1);
      rb_re = fas_round_shift(rb_re, 1);
      rb_im = fas_round_shift(rb_im, 1);
    end
    sat_any = fas_sat_ovf(ra_re, DW) | fas_sat_ovf(ra_im, DW) |
              fas_sat_ovf(rb_re, DW) | fas_sat_ovf(rb_im, DW);

    a_re_d = en ? DW'(fas_sat(ra_re, DW)) : a_re_q;
    a_im_d = en ? DW'(fas_sat(ra_im, DW)) : a_im_q;
    b_re_d = en ? DW'(fas_sat(rb_re, DW)) : b_re_q;
    b_im_d = en ? DW'(fas_sat(rb_im, DW)) : b_im_q;

    // Only a clamp on a sample actually being emitted counts; set beats clear.
    if (en && vld_pipe_q[1] && sat_any) ovf_d = 1'b1;
    else if (clr_ovf)                   ovf_d = 1'b0;
    else                                ovf_d = ovf_q;
  end

  fas_cmul #(.AW(SW), .BW(DW), .FRAC(FRAC)) u_cmul (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a_re (s1_p1_re_q),
    .a_im (s1_p1_im_q),
    .b_re (s1_w_re_q),
    .b_im (s1_w_im_q),
    .p_re (s2_pr_re),
    .p_im (s2_pr_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q   <= '0;
      mode_pipe_q  <= '0;
      scale_pipe_q <= '0;
      s1_p0_re_q   <= '0;
      s1_p0_im_q   <= '0;
      s1_p1_re_q   <= '0;
      s1_p1_im_q   <= '0;
      s1_w_re_q    <= '0;
      s1_w_im_q    <= '0;
      s2_p0_re_q   <= '0;
      s2_p0_im_q   <= '0;
      a_re_q       <= '0;
      a_im_q       <= '0;
      b_re_q       <= '0;
      b_im_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      mode_pipe_q  <= mode_pipe_d;
      scale_pipe_q <= scale_pipe_d;
      s1_p0_re_q   <= s1_p0_re_d;
      s1_p0_im_q   <= s1_p0_im_d;
      s1_p1_re_q   <= s1_p1_re_d;
      s1_p1_im_q   <= s1_p1_im_d;
      s1_w_re_q    <= s1_w_re_d;
      s1_w_im_q    <= s1_w_im_d;
      s2_p0_re_q   <= s2_p0_re_d;
      s2_p0_im_q   <= s2_p0_im_d;
      a_re_q       <= a_re_d;
      a_im_q       <= a_im_d;
      b_re_q       <= b_re_d;
      b_im_q       <= b_im_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign a_re      = a_re_q;
  assign a_im      = a_im_q;
  assign b_re      = b_re_q;
  assign b_im      = b_im_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb_fft_bfly_pipe: directed + randomized bench for fft_bfly_pipe (DW=32,
// FRAC=16). A behavioural model computes each butterfly result with wide
// integer arithmetic when a sample is accepted and queues it with the
// enabled-edge count at which it must appear on the outputs.
module tb_fft_bfly_pipe;

  localparam int DW   = 32;
  localparam int FRAC = 16;

  typedef logic signed [127:0] big_t;
  typedef struct {
    int unsigned due;
    logic [31:0] ar, ai, br, bi;
    bit          ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, in_valid = 1'b0, mode = 1'b0, scale = 1'b0, clr_ovf = 1'b0;
  logic [31:0] x_re = '0, x_im = '0, y_re = '0, y_im = '0, w_re = '0, w_im = '0;
  logic        out_valid, ovf;
  logic [31:0] a_re, a_im, b_re, b_im;

  fft_bfly_pipe #(.DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode), .scale(scale),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic big_t sx(input logic [31:0] v);
    return {{96{v[31]}}, v};
  endfunction

  function automatic big_t rnd_q(input big_t v);
    return (v + (big_t'(1) <<< (FRAC - 1))) >>> FRAC;
  endfunction

  function automatic big_t halve(input big_t v);
    return (v + big_t'(1)) >>> 1;
  endfunction

  function automatic logic [31:0] clamp(input big_t v, inout bit ov);
    big_t hi, lo;
    hi = big_t'(32'h7FFFFFFF);
    lo = -hi - big_t'(1);
    if (v > hi) begin ov = 1'b1; return 32'h7FFFFFFF; end
    if (v < lo) begin ov = 1'b1; return 32'h80000000; end
    return v[31:0];
  endfunction

  function automatic exp_t model_bfly(input logic [31:0] xr_i, xi_i, yr_i, yi_i, wr_i, wi_i,
                                      input logic m, s);
    exp_t e;
    big_t xr, xi, yr, yi, wr, wi, ar, ai, br, bi, dr, di, tr, ti;
    bit ov;
    xr = sx(xr_i); xi = sx(xi_i); yr = sx(yr_i); yi = sx(yi_i); wr = sx(wr_i); wi = sx(wi_i);
    if (!m) begin
      ar = xr + yr; ai = xi + yi;
      dr = xr - yr; di = xi - yi;
      br = rnd_q(dr * wr - di * wi);
      bi = rnd_q(dr * wi + di * wr);
    end else begin
      tr = rnd_q(yr * wr - yi * wi);
      ti = rnd_q(yr * wi + yi * wr);
      ar = xr + tr; ai = xi + ti;
      br = xr - tr; bi = xi - ti;
    end
    if (s) begin ar = halve(ar); ai = halve(ai); br = halve(br); bi = halve(bi); end
    ov = 1'b0;
    e.ar = clamp(ar, ov); e.ai = clamp(ai, ov);
    e.br = clamp(br, ov); e.bi = clamp(bi, ov);
    e.ov = ov;
    e.due = 0;
    return e;
  endfunction

  exp_t        q[$];
  int unsigned en_cnt = 0;
  bit          ovf_m = 1'b0;
  bit          chk_on = 1'b0;
  int          cyc = 0;
  bit          lat_arm = 1'b0;
  int          t0 = 0, lat = -1;

  // Model advance on every clock edge, from the same inputs the DUT samples.
  always @(posedge clk) begin : model_p
    exp_t e;
    bit   set;
    cyc++;
    if (rst) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      set = 1'b0;
      if (en) begin
        en_cnt++;
        while (q.size() > 0 && q[0].due < en_cnt) void'(q.pop_front());
        if (q.size() > 0 && q[0].due == en_cnt && q[0].ov) set = 1'b1;
        if (in_valid) begin
          e = model_bfly(x_re, x_im, y_re, y_im, w_re, w_im, mode, scale);
          e.due = en_cnt + 2;
          q.push_back(e);
        end
      end
      if (set)          ovf_m = 1'b1;
      else if (clr_ovf) ovf_m = 1'b0;
    end
  end

  // Compare on the falling edge, away from the sampling edge.
  always @(negedge clk) begin : cmp_p
    bit ev;
    if (chk_on) begin
      ev = 1'b0;
      if (q.size() > 0) ev = (q[0].due == en_cnt);
      chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
      chk("ovf", {63'd0, ovf}, {63'd0, ovf_m});
      if (ev) begin
        chk("a_re", {32'd0, a_re}, {32'd0, q[0].ar});
        chk("a_im", {32'd0, a_im}, {32'd0, q[0].ai});
        chk("b_re", {32'd0, b_re}, {32'd0, q[0].br});
        chk("b_im", {32'd0, b_im}, {32'd0, q[0].bi});
      end
      if (lat_arm && out_valid) begin
        lat = cyc - t0;
        lat_arm = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [31:0] xr, xi, yr, yi, wr, wi, input logic m, s);
    x_re = xr; x_im = xi; y_re = yr; y_im = yi; w_re = wr; w_im = wi; mode = m; scale = s;
  endtask

  task automatic send(input logic [31:0] xr, xi, yr, yi, wr, wi, input logic m, s);
    set_in(xr, xi, yr, yi, wr, wi, m, s);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rword();
    case ($urandom_range(3))
      0: return $urandom();
      1: return 32'($urandom_range(2097152)) - 32'd1048576;
      2: return ($urandom_range(1) != 0) ? 32'h7FFFFFFF - 32'($urandom_range(255))
                                         : 32'h80000000 + 32'($urandom_range(255));
      default: return 32'($urandom_range(131072)) - 32'd65536;
    endcase
  endfunction

  function automatic logic [31:0] rtw();
    if ($urandom_range(7) == 0) return $urandom();
    return 32'($urandom_range(131072)) - 32'd65536;
  endfunction

  initial begin : main
    exp_t e;
    int   seen;
    // model pins from hand-derived values
    e = model_bfly(32'h00010000, 0, 32'h00008000, 0, 0, 32'hFFFF0000, 1'b0, 1'b0);
    chk("pin_dif_a_re", {32'd0, e.ar}, 64'h18000);
    chk("pin_dif_b_im", {32'd0, e.bi}, 64'hFFFF8000);
    e = model_bfly(32'h00010000, 0, 32'h00008000, 0, 32'h00010000, 0, 1'b1, 1'b0);
    chk("pin_dit_b_re", {32'd0, e.br}, 64'h8000);
    e = model_bfly(32'h00000001, 0, 0, 0, 32'h00010000, 0, 1'b0, 1'b1);
    chk("pin_round_a_re", {32'd0, e.ar}, 64'h1);

    idle(3);
    rst = 1'b0; en = 1'b1;
    chk_on = 1'b1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_a_re", {32'd0, a_re}, 64'd0);
    chk("rst_b_im", {32'd0, b_im}, 64'd0);

    // DIF basic
    send(32'h00010000, 0, 32'h00008000, 0, 0, 32'hFFFF0000, 1'b0, 1'b0);
    idle(2);
    chk("dif_valid", {63'd0, out_valid}, 64'd1);
    chk("dif_a_re", {32'd0, a_re}, 64'h18000);
    chk("dif_a_im", {32'd0, a_im}, 64'h0);
    chk("dif_b_re", {32'd0, b_re}, 64'h0);
    chk("dif_b_im", {32'd0, b_im}, 64'hFFFF8000);
    chk("dif_ovf", {63'd0, ovf}, 64'd0);

    // DIT basic
    send(32'h00010000, 0, 32'h00008000, 0, 32'h00010000, 0, 1'b1, 1'b0);
    idle(2);
    chk("dit_a_re", {32'd0, a_re}, 64'h18000);
    chk("dit_b_re", {32'd0, b_re}, 64'h8000);
    chk("dit_b_im", {32'd0, b_im}, 64'h0);

    // Saturation and sticky flag
    send(32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h00010000, 0, 1'b0, 1'b0);
    idle(2);
    chk("sat_a_re", {32'd0, a_re}, 64'h7FFFFFFF);
    chk("sat_ovf", {63'd0, ovf}, 64'd1);
    repeat (10) send(32'h00001234, 32'h00000100, 32'h00000200, 32'hFFFFF000, 32'h00008000, 0, 1'b0, 1'b0);
    idle(3);
    chk("ovf_sticky", {63'd0, ovf}, 64'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clear", {63'd0, ovf}, 64'd0);

    // Scaling and rounding
    send(32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h00010000, 0, 1'b0, 1'b1);
    idle(2);
    chk("scale_a_re", {32'd0, a_re}, 64'h7FFFFFFF);
    chk("scale_ovf", {63'd0, ovf}, 64'd0);
    send(32'h00000001, 0, 0, 0, 32'h00010000, 0, 1'b0, 1'b1);
    idle(2);
    chk("round_a_re", {32'd0, a_re}, 64'h1);

    // Clear coincident with a new overflow: set wins
    send(32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h00010000, 0, 1'b0, 1'b0);
    idle(1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", {63'd0, ovf}, 64'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;

    // Stall mid-stream with alternating modes
    idle(3);
    t0 = cyc; lat_arm = 1'b1;
    send(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b0, 1'b0);
    send(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b1, 1'b0);
    en = 1'b0;
    idle(2);
    en = 1'b1;
    send(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b0, 1'b1);
    send(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b1, 1'b0);
    send(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b0, 1'b0);
    idle(6);
    chk("stall_latency", 64'(lat), 64'd5);

    // in_valid gaps
    send(32'h00020000, 0, 32'h00010000, 0, 32'h00010000, 0, 1'b1, 1'b0);
    idle(1);
    send(32'h00030000, 0, 32'h00010000, 0, 32'h00010000, 0, 1'b0, 1'b0);
    idle(2);
    send(32'h00040000, 0, 32'h00010000, 0, 32'h00010000, 0, 1'b1, 1'b1);
    idle(4);

    // Reset mid-stream with samples in flight and ovf set
    send(32'h80000000, 0, 32'h80000000, 0, 32'h00010000, 0, 1'b0, 1'b0);
    idle(3);
    send(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b0, 1'b0);
    send(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b1, 1'b0);
    set_in(rword(), rword(), rword(), rword(), rtw(), rtw(), 1'b0, 1'b0);
    in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ovf", {63'd0, ovf}, 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", 64'(seen), 64'd0);

    // Randomized phase
    repeat (3000) begin
      rst      = ($urandom_range(199) == 0);
      en       = ($urandom_range(9) != 0);
      in_valid = en && ($urandom_range(9) < 7);
      clr_ovf  = ($urandom_range(29) == 0);
      set_in(rword(), rword(), rword(), rword(), rtw(), rtw(),
             1'($urandom_range(1)), 1'($urandom_range(1)));
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; clr_ovf = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
